// File: rtl/beta_pkg.sv
// Shared Beta ISA constants, opcode map, trap causes and trap-FSM states
// used by the decode_xp slice.
package beta_pkg;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // opcode[5:4] selects the register-operand and literal-operand ALU groups
  localparam logic [1:0] OPG_ALU  = 2'b10;
  localparam logic [1:0] OPG_ALUC = 2'b11;

  localparam logic [4:0] REG_XP   = 5'd30;
  localparam logic [4:0] REG_ZERO = 5'd31;

  localparam logic [31:0] INST_NOP        = {6'h20, REG_ZERO, REG_ZERO, REG_ZERO, 11'd0};
  localparam logic [31:0] INST_BNE_EXCEPT = {OP_BNE, REG_XP, REG_ZERO, 16'd0};

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_ILLOP = 2'd1,
    CAUSE_IRQ   = 2'd2
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_DRAIN = 2'd2
  } xp_state_e;

  // R31 reads as zero, so it never takes part in forwarding or hazards
  function automatic logic reg_match(input logic [4:0] ra, input logic [4:0] rc);
    return (ra == rc) && (ra != REG_ZERO);
  endfunction

endpackage

// File: rtl/decode_xp_illop.sv
// Legal-opcode checker: the memory/branch group entries plus both ALU groups.
module decode_xp_illop
  import beta_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       illegal
);

  assign illegal = !((opcode[5:4] == OPG_ALU) || (opcode[5:4] == OPG_ALUC) ||
                     (opcode inside {OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR}));

endmodule

// File: rtl/operand_mux.sv
// Bypass selection for one register operand: ex > mem > wb > register file.
// Stores in a later stage write no register and are never forwarded.
module operand_mux
  import beta_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      ra,
  input  logic [XLEN-1:0] rf_data,
  input  logic [4:0]      rc_ex,
  input  logic [4:0]      rc_mem,
  input  logic [4:0]      rc_wb,
  input  logic            op_br_or_jmp_ex,
  input  logic            op_br_or_jmp_mem,
  input  logic            op_st_ex,
  input  logic            op_st_mem,
  input  logic            op_st_wb,
  input  logic [XLEN-1:0] ex_y_bypass,
  input  logic [XLEN-1:0] ex_pc_bypass,
  input  logic [XLEN-1:0] mem_y_bypass,
  input  logic [XLEN-1:0] mem_pc_bypass,
  input  logic [XLEN-1:0] wb_bypass,
  output logic [XLEN-1:0] data
);

  logic hit_ex, hit_mem, hit_wb;

  assign hit_ex  = !op_st_ex  && reg_match(ra, rc_ex);
  assign hit_mem = !op_st_mem && reg_match(ra, rc_mem);
  assign hit_wb  = !op_st_wb  && reg_match(ra, rc_wb);

  // Branches and jumps write PC+4 to Rc, carried on the *_pc_bypass buses
  always_comb begin
    if (hit_ex)       data = op_br_or_jmp_ex  ? ex_pc_bypass  : ex_y_bypass;
    else if (hit_mem) data = op_br_or_jmp_mem ? mem_pc_bypass : mem_y_bypass;
    else if (hit_wb)  data = wb_bypass;
    else              data = rf_data;
  end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN register file: two asynchronous read ports, one write port.
// R31 is hard-wired to zero on read and never written.
module reg_file
  import beta_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            we,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [0:31];

  // NOTE: the array has no reset; software initialises registers, and a reset
  // port on a storage array would stop it mapping onto RAM/regfile macros.
  always_ff @(posedge clk) begin
    if (we && (wa != REG_ZERO)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == REG_ZERO) ? '0 : regs[ra1];
  assign rd2 = (ra2 == REG_ZERO) ? '0 : regs[ra2];

endmodule

// File: rtl/decode_xp.sv
// Beta decode stage with operand bypass, load-use stall and trap sequencing.
// Define DECODE_XP_IRQ_EN to enable external interrupt trapping on irq.
module decode_xp
  import beta_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SUP_BIT = XLEN - 1,
  parameter int CAUSE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc,
  input  logic [31:0]        ir,
  output logic [XLEN-1:0]    d_next,
  output logic [XLEN-1:0]    a_next,
  output logic [XLEN-1:0]    b_next,
  output logic [XLEN-1:0]    pc_next,
  output logic [31:0]        ir_next,
  output logic               op_jmp,
  output logic               op_beq,
  output logic               op_bne,
  output logic               zr,
  output logic [XLEN-1:0]    j_addr,
  output logic [XLEN-1:0]    br_addr,
  output logic               stall,
  output logic               exc_req,
  output logic [CAUSE_W-1:0] exc_cause,
  input  logic               redirect_ack,
  input  logic               irq,
  input  logic               op_ld_or_ldr_ex,
  input  logic               op_ld_or_ldr_mem,
  input  logic               op_br_or_jmp_ex,
  input  logic               op_br_or_jmp_mem,
  input  logic               op_st_ex,
  input  logic               op_st_mem,
  input  logic               op_st_wb,
  input  logic [4:0]         rc_ex,
  input  logic [4:0]         rc_mem,
  input  logic [4:0]         rc_wb,
  input  logic [XLEN-1:0]    ex_y_bypass,
  input  logic [XLEN-1:0]    ex_pc_bypass,
  input  logic [XLEN-1:0]    mem_y_bypass,
  input  logic [XLEN-1:0]    mem_pc_bypass,
  input  logic [XLEN-1:0]    wb_bypass,
  input  logic [4:0]         rf_w_addr,
  input  logic [XLEN-1:0]    rf_w_data,
  input  logic               rf_we
);

  logic [XLEN-1:0] pc_decode;
  logic [31:0]     ir_decode;
  xp_state_e       state, state_nxt;
  cause_e          cause;

  logic [5:0]      opcode;
  logic [4:0]      ra1, ra2;
  logic            is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_alu, is_aluc;
  logic            reads_ra2, illegal, irq_hit, stall_raw, idle;
  logic [XLEN-1:0] lit_sext, rd1_rf, rd2_rf, rd1, rd2;

  assign opcode  = ir_decode[31:26];
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_jmp  = (opcode == OP_JMP);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_ldr  = (opcode == OP_LDR);
  assign is_alu  = (opcode[5:4] == OPG_ALU);
  assign is_aluc = (opcode[5:4] == OPG_ALUC);

  // Stores read their data register through the second port
  assign ra1       = ir_decode[20:16];
  assign ra2       = is_st ? ir_decode[25:21] : ir_decode[15:11];
  assign reads_ra2 = is_st || is_alu;
  assign lit_sext  = {{(XLEN-16){ir_decode[15]}}, ir_decode[15:0]};

  decode_xp_illop u_illop (
    .opcode  (opcode),
    .illegal (illegal)
  );

  reg_file #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa  (rf_w_addr),
    .wd  (rf_w_data),
    .we  (rf_we),
    .rd1 (rd1_rf),
    .rd2 (rd2_rf)
  );

  operand_mux #(.XLEN(XLEN)) u_mux_a (
    .ra (ra1), .rf_data (rd1_rf),
    .rc_ex (rc_ex), .rc_mem (rc_mem), .rc_wb (rc_wb),
    .op_br_or_jmp_ex (op_br_or_jmp_ex), .op_br_or_jmp_mem (op_br_or_jmp_mem),
    .op_st_ex (op_st_ex), .op_st_mem (op_st_mem), .op_st_wb (op_st_wb),
    .ex_y_bypass (ex_y_bypass), .ex_pc_bypass (ex_pc_bypass),
    .mem_y_bypass (mem_y_bypass), .mem_pc_bypass (mem_pc_bypass),
    .wb_bypass (wb_bypass), .data (rd1)
  );

  operand_mux #(.XLEN(XLEN)) u_mux_b (
    .ra (ra2), .rf_data (rd2_rf),
    .rc_ex (rc_ex), .rc_mem (rc_mem), .rc_wb (rc_wb),
    .op_br_or_jmp_ex (op_br_or_jmp_ex), .op_br_or_jmp_mem (op_br_or_jmp_mem),
    .op_st_ex (op_st_ex), .op_st_mem (op_st_mem), .op_st_wb (op_st_wb),
    .ex_y_bypass (ex_y_bypass), .ex_pc_bypass (ex_pc_bypass),
    .mem_y_bypass (mem_y_bypass), .mem_pc_bypass (mem_pc_bypass),
    .wb_bypass (wb_bypass), .data (rd2)
  );

  // Load data is not available until wb, so a hit in ex or mem must wait
  assign stall_raw =
    (op_ld_or_ldr_ex  && (reg_match(ra1, rc_ex)  || (reads_ra2 && reg_match(ra2, rc_ex)))) ||
    (op_ld_or_ldr_mem && (reg_match(ra1, rc_mem) || (reads_ra2 && reg_match(ra2, rc_mem))));

  assign idle  = (state == ST_IDLE);
  assign stall = idle && stall_raw;

`ifdef DECODE_XP_IRQ_EN
  // No interrupt in supervisor mode or in a branch shadow
  assign irq_hit = irq && !pc_decode[SUP_BIT] && !(is_jmp || is_beq || is_bne);
`else
  logic unused_irq;
  assign unused_irq = irq & pc_decode[SUP_BIT];
  assign irq_hit    = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ir_next   = ir_decode;
    exc_req   = 1'b0;
    cause     = CAUSE_NONE;
    unique case (state)
      ST_IDLE: begin
        if (stall_raw) begin
          ir_next = INST_NOP;
        end else if (illegal || irq_hit) begin
          ir_next   = INST_BNE_EXCEPT;
          exc_req   = 1'b1;
          cause     = illegal ? CAUSE_ILLOP : CAUSE_IRQ;
          state_nxt = ST_TRAP;
        end
      end
      ST_TRAP: begin
        ir_next   = INST_NOP;
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        ir_next = INST_NOP;
        if (redirect_ack) state_nxt = ST_IDLE;
      end
      default: begin
        ir_next   = INST_NOP;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ir_decode <= INST_NOP;
      pc_decode <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DRAIN) begin
        ir_decode <= INST_NOP;
      end else if (!stall) begin
        ir_decode <= ir;
        pc_decode <= pc;
      end
    end
  end

  assign exc_cause = CAUSE_W'(cause);
  assign pc_next   = pc_decode;
  assign br_addr   = pc_decode + (lit_sext << 2);
  assign j_addr    = rd1;
  assign zr        = (rd1 == '0);
  assign a_next    = is_ldr ? br_addr : rd1;
  assign b_next    = (is_ld || is_st || is_aluc) ? lit_sext : rd2;
  assign d_next    = rd2;
  assign op_jmp    = idle && is_jmp;
  assign op_beq    = idle && is_beq;
  assign op_bne    = idle && is_bne;

endmodule

// File: tb/tb_decode_xp.sv
// Directed bench for decode_xp: table of single-cycle decode vectors plus
// hand-written trap, stall, interrupt and reset sequences.
module tb_decode_xp;

  localparam logic [31:0] NOP     = 32'h83FF_F800;
  localparam logic [31:0] BNE_EXC = 32'h77DF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, ir;
  logic [31:0] d_next, a_next, b_next, pc_next, ir_next, j_addr, br_addr;
  logic        op_jmp, op_beq, op_bne, zr, stall, exc_req;
  logic [1:0]  exc_cause;
  logic        redirect_ack, irq;
  logic        op_ld_or_ldr_ex, op_ld_or_ldr_mem, op_br_or_jmp_ex, op_br_or_jmp_mem;
  logic        op_st_ex, op_st_mem, op_st_wb;
  logic [4:0]  rc_ex, rc_mem, rc_wb, rf_w_addr;
  logic [31:0] ex_y_bypass, ex_pc_bypass, mem_y_bypass, mem_pc_bypass, wb_bypass, rf_w_data;
  logic        rf_we;

  int total = 0;
  int bad   = 0;

  decode_xp #(.XLEN(32)) dut (
    .clk (clk), .rst (rst), .pc (pc), .ir (ir),
    .d_next (d_next), .a_next (a_next), .b_next (b_next), .pc_next (pc_next),
    .ir_next (ir_next), .op_jmp (op_jmp), .op_beq (op_beq), .op_bne (op_bne), .zr (zr),
    .j_addr (j_addr), .br_addr (br_addr), .stall (stall),
    .exc_req (exc_req), .exc_cause (exc_cause), .redirect_ack (redirect_ack), .irq (irq),
    .op_ld_or_ldr_ex (op_ld_or_ldr_ex), .op_ld_or_ldr_mem (op_ld_or_ldr_mem),
    .op_br_or_jmp_ex (op_br_or_jmp_ex), .op_br_or_jmp_mem (op_br_or_jmp_mem),
    .op_st_ex (op_st_ex), .op_st_mem (op_st_mem), .op_st_wb (op_st_wb),
    .rc_ex (rc_ex), .rc_mem (rc_mem), .rc_wb (rc_wb),
    .ex_y_bypass (ex_y_bypass), .ex_pc_bypass (ex_pc_bypass),
    .mem_y_bypass (mem_y_bypass), .mem_pc_bypass (mem_pc_bypass), .wb_bypass (wb_bypass),
    .rf_w_addr (rf_w_addr), .rf_w_data (rf_w_data), .rf_we (rf_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, pc;
    logic [4:0]  rc_ex, rc_mem, rc_wb;
    logic        ex_ld, ex_brj, ex_st, mem_ld;
    logic [31:0] e_ir, e_a, e_b, e_d, e_br, e_j;
    logic        e_stall;
    logic [3:0]  e_ctl;  // {op_jmp, op_beq, op_bne, zr}
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] enci(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctx();
    op_ld_or_ldr_ex = 0; op_ld_or_ldr_mem = 0; op_br_or_jmp_ex = 0; op_br_or_jmp_mem = 0;
    op_st_ex = 0; op_st_mem = 0; op_st_wb = 0;
    rc_ex = 5'd31; rc_mem = 5'd31; rc_wb = 5'd31;
  endtask

  // From the trap-request cycle: through TRAP and DRAIN, ack, back in IDLE
  task automatic drain_out();
    tick();
    tick();
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] add1, addc_m4, st1, ldr1, beq1, bne1, jmp1, add_z, addc7, add2, ill0, ill2, hnd;
    add1    = enc (6'h20, 5'd5, 5'd1, 5'd2);
    add2    = enc (6'h20, 5'd6, 5'd2, 5'd3);
    hnd     = enc (6'h20, 5'd6, 5'd1, 5'd3);
    add_z   = enc (6'h20, 5'd5, 5'd31, 5'd2);
    addc_m4 = enci(6'h30, 5'd5, 5'd1, 16'hFFFC);
    addc7   = enci(6'h30, 5'd5, 5'd1, 16'h3800);
    st1     = enci(6'h19, 5'd3, 5'd1, 16'h0008);
    ldr1    = enci(6'h1F, 5'd6, 5'd31, 16'h0010);
    beq1    = enci(6'h1C, 5'd31, 5'd4, 16'hFFFF);
    bne1    = enci(6'h1D, 5'd31, 5'd1, 16'h0002);
    jmp1    = enci(6'h1B, 5'd31, 5'd2, 16'h0000);
    ill0    = 32'h0000_0000;
    ill2    = {6'h00, 5'd2, 5'd1, 16'h0000};

    //           ir       pc            ex  mem wb  ld brj st mld e_ir  e_a           e_b           e_d           e_br          e_j        stl ctl
    vecs[0]  = '{add1,    32'h100, 31, 31, 31, 0, 0, 0, 0, add1,    32'h11,       32'h22,       32'h22,       32'h4100, 32'h11,       0, 4'b0000};
    vecs[1]  = '{addc_m4, 32'h100, 31, 31, 31, 0, 0, 0, 0, addc_m4, 32'h11,       32'hFFFFFFFC, 32'h0,        32'h0F0,  32'h11,       0, 4'b0000};
    vecs[2]  = '{st1,     32'h100, 31, 31, 31, 0, 0, 0, 0, st1,     32'h11,       32'h8,        32'h33,       32'h120,  32'h11,       0, 4'b0000};
    vecs[3]  = '{ldr1,    32'h200, 31, 31, 31, 0, 0, 0, 0, ldr1,    32'h240,      32'h0A,       32'h0A,       32'h240,  32'h0,        0, 4'b0001};
    vecs[4]  = '{beq1,    32'h300, 31, 31, 31, 0, 0, 0, 0, beq1,    32'h0,        32'h0,        32'h0,        32'h2FC,  32'h0,        0, 4'b0101};
    vecs[5]  = '{bne1,    32'h300, 31, 31, 31, 0, 0, 0, 0, bne1,    32'h11,       32'h0A,       32'h0A,       32'h308,  32'h11,       0, 4'b0010};
    vecs[6]  = '{jmp1,    32'h400, 31, 31, 31, 0, 0, 0, 0, jmp1,    32'h22,       32'h0A,       32'h0A,       32'h400,  32'h22,       0, 4'b1000};
    vecs[7]  = '{add1,    32'h100,  1, 31, 31, 0, 0, 0, 0, add1,    32'hE0E00001, 32'h22,       32'h22,       32'h4100, 32'hE0E00001, 0, 4'b0000};
    vecs[8]  = '{add1,    32'h100,  2, 31, 31, 0, 1, 0, 0, add1,    32'h11,       32'hE0E00002, 32'hE0E00002, 32'h4100, 32'h11,       0, 4'b0000};
    vecs[9]  = '{add1,    32'h100,  1,  1, 31, 0, 0, 1, 0, add1,    32'hA0A00003, 32'h22,       32'h22,       32'h4100, 32'hA0A00003, 0, 4'b0000};
    vecs[10] = '{add_z,   32'h100, 31, 31,  2, 0, 0, 0, 0, add_z,   32'h0,        32'hB0B00005, 32'hB0B00005, 32'h4100, 32'h0,        0, 4'b0001};
    vecs[11] = '{st1,     32'h100, 31,  3, 31, 0, 0, 0, 1, NOP,     32'h11,       32'h8,        32'hA0A00003, 32'h120,  32'h11,       1, 4'b0000};
    vecs[12] = '{addc7,   32'h100,  7, 31, 31, 1, 0, 0, 0, addc7,   32'h11,       32'h3800,     32'hE0E00001, 32'hE100, 32'h11,       0, 4'b0000};

    ex_y_bypass = 32'hE0E00001; ex_pc_bypass = 32'hE0E00002;
    mem_y_bypass = 32'hA0A00003; mem_pc_bypass = 32'hA0A00004; wb_bypass = 32'hB0B00005;
    clear_ctx();
    redirect_ack = 0; irq = 0; rf_we = 0; rf_w_addr = 0; rf_w_data = 0;
    pc = 32'h0; ir = add1;

    // Reset, loading the register file meanwhile
    rst = 1;
    #2;
    for (int r = 0; r < 5; r++) begin
      rf_we = 1; rf_w_addr = 5'(r);
      rf_w_data = (r == 0) ? 32'h0A : (r == 4) ? 32'h0 : 32'(r * 32'h11);
      tick();
    end
    rf_we = 0;
    check("rst ir_next", ir_next, NOP);
    check("rst exc_req", 32'(exc_req), 32'h0);
    check("rst exc_cause", 32'(exc_cause), 32'h0);
    check("rst stall", 32'(stall), 32'h0);
    check("rst pc_next", pc_next, 32'h0);
    rst = 0;
    pc = 32'h100;
    tick();
    check("post-rst ir_next", ir_next, add1);

    // Table of single-cycle decode vectors
    for (int i = 0; i < 13; i++) begin
      ir = vecs[i].ir; pc = vecs[i].pc;
      clear_ctx();
      tick();
      rc_ex = vecs[i].rc_ex; rc_mem = vecs[i].rc_mem; rc_wb = vecs[i].rc_wb;
      op_ld_or_ldr_ex = vecs[i].ex_ld; op_br_or_jmp_ex = vecs[i].ex_brj;
      op_st_ex = vecs[i].ex_st; op_ld_or_ldr_mem = vecs[i].mem_ld;
      #1;
      check($sformatf("vec%0d ir_next", i), ir_next, vecs[i].e_ir);
      check($sformatf("vec%0d a_next", i), a_next, vecs[i].e_a);
      check($sformatf("vec%0d b_next", i), b_next, vecs[i].e_b);
      check($sformatf("vec%0d d_next", i), d_next, vecs[i].e_d);
      check($sformatf("vec%0d br_addr", i), br_addr, vecs[i].e_br);
      check($sformatf("vec%0d j_addr", i), j_addr, vecs[i].e_j);
      check($sformatf("vec%0d pc_next", i), pc_next, vecs[i].pc);
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d ctl", i), 32'({op_jmp, op_beq, op_bne, zr}), 32'(vecs[i].e_ctl));
      check($sformatf("vec%0d exc_req", i), 32'(exc_req), 32'h0);
    end
    clear_ctx();

    // Load-use: LD R1 in ex then mem, ADD reading R1 held two cycles
    ir = add1; pc = 32'h100;
    tick();
    ir = add2;
    op_ld_or_ldr_ex = 1; rc_ex = 5'd1;
    #1;
    check("lu ex stall", 32'(stall), 32'h1);
    check("lu ex ir_next", ir_next, NOP);
    tick();
    clear_ctx();
    op_ld_or_ldr_mem = 1; rc_mem = 5'd1;
    #1;
    check("lu mem stall", 32'(stall), 32'h1);
    check("lu mem ir_next", ir_next, NOP);
    tick();
    clear_ctx();
    rc_wb = 5'd1;
    #1;
    check("lu wb stall", 32'(stall), 32'h0);
    check("lu wb ir_next", ir_next, add1);
    check("lu wb a_next", a_next, 32'hB0B00005);
    tick();
    clear_ctx();
    #1;
    check("lu next ir_next", ir_next, add2);

    // Illegal opcode at 0x104: trap, drain, redirect
    ir = ill0; pc = 32'h104;
    tick();
    check("ill ir_next", ir_next, BNE_EXC);
    check("ill pc_next", pc_next, 32'h104);
    check("ill exc_req", 32'(exc_req), 32'h1);
    check("ill exc_cause", 32'(exc_cause), 32'h1);
    ir = beq1; redirect_ack = 1;
    tick();
    check("trap ir_next", ir_next, NOP);
    check("trap exc_req", 32'(exc_req), 32'h0);
    check("trap exc_cause", 32'(exc_cause), 32'h0);
    redirect_ack = 0;
    tick();
    op_ld_or_ldr_ex = 1; rc_ex = 5'd4;
    #1;
    check("drain ir_next", ir_next, NOP);
    check("drain op_beq", 32'(op_beq), 32'h0);
    check("drain stall", 32'(stall), 32'h0);
    clear_ctx();
    tick();
    check("drain2 ir_next", ir_next, NOP);
    redirect_ack = 1;
    tick();
    redirect_ack = 0; ir = hnd; pc = 32'h4;
    check("ack ir_next", ir_next, NOP);
    check("ack exc_req", 32'(exc_req), 32'h0);
    tick();
    check("handler ir_next", ir_next, hnd);

    // Illegal opcode behind a load-use stall: trap deferred
    ir = ill2; pc = 32'h108;
    tick();
    op_ld_or_ldr_ex = 1; rc_ex = 5'd1;
    #1;
    check("ill-stall exc_req", 32'(exc_req), 32'h0);
    check("ill-stall stall", 32'(stall), 32'h1);
    check("ill-stall ir_next", ir_next, NOP);
    ir = add1;
    tick();
    clear_ctx();
    #1;
    check("ill-after exc_req", 32'(exc_req), 32'h1);
    check("ill-after exc_cause", 32'(exc_cause), 32'h1);
    check("ill-after pc_next", pc_next, 32'h108);
    drain_out();

`ifdef DECODE_XP_IRQ_EN
    irq = 1; ir = enci(6'h1C, 5'd31, 5'd4, 16'h0001); pc = 32'h1FC;
    tick();
    check("irq beq exc_req", 32'(exc_req), 32'h0);
    check("irq beq op_beq", 32'(op_beq), 32'h1);
    ir = add1; pc = 32'h200;
    tick();
    check("irq exc_req", 32'(exc_req), 32'h1);
    check("irq exc_cause", 32'(exc_cause), 32'h2);
    check("irq ir_next", ir_next, BNE_EXC);
    check("irq pc_next", pc_next, 32'h200);
    irq = 0;
    drain_out();
    irq = 1; ir = enci(6'h1C, 5'd31, 5'd4, 16'h0001); pc = 32'h8000_01FC;
    tick();
    check("sup beq exc_req", 32'(exc_req), 32'h0);
    ir = add1; pc = 32'h8000_0200;
    tick();
    check("sup add exc_req", 32'(exc_req), 32'h0);
    check("sup add ir_next", ir_next, add1);
`else
    irq = 1; ir = add1; pc = 32'h200;
    tick();
    check("irq-off exc_req", 32'(exc_req), 32'h0);
    check("irq-off ir_next", ir_next, add1);
`endif
    ir = ill0; pc = 32'h204;
    tick();
    check("ill+irq exc_req", 32'(exc_req), 32'h1);
    check("ill+irq exc_cause", 32'(exc_cause), 32'h1);
    irq = 0;
    drain_out();

    // Reset asserted in DRAIN
    ir = ill0; pc = 32'h104;
    tick();
    check("rd trap exc_req", 32'(exc_req), 32'h1);
    tick();
    tick();
    check("rd drain ir_next", ir_next, NOP);
    rst = 1;
    #1;
    check("rd rst ir_next", ir_next, NOP);
    check("rd rst exc_req", 32'(exc_req), 32'h0);
    check("rd rst pc_next", pc_next, 32'h0);
    ir = add2; pc = 32'h300;
    rst = 0;
    tick();
    check("rd fresh ir_next", ir_next, add2);
    check("rd fresh exc_req", 32'(exc_req), 32'h0);
    ir = add1;
    tick();
    check("rd second ir_next", ir_next, add1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
